// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 keyboard receiver.
// Frame layout: start, 8 data bits LSB first, odd parity, stop.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = FRAME_BITS - 3;

    function automatic logic odd_parity_ok(
        input logic [7:0] b,
        input logic       p
    );
        return ^{b, p};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus run-length deglitcher for one PS/2 pin.
// Emits the filtered level and a one-cycle falling-edge pulse.
module ps2_line_filter #(
    parameter int FILTER = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser; the bus idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], pin};
        end
    end

    // Flip the level only after FILTER samples disagree with it in a row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER - 1)) begin
                level <= sync[1];
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 set-2 frame receiver feeding a paced byte-strobe stream.
// Good bytes go through a small FIFO; bad frames raise parity_err.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER      = 8,
    parameter int TIMEOUT_CYC = 32000,
    parameter int FIFO_DEPTH  = 4,
    parameter int STROBE_GAP  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       kbd_strobe,
    output logic [7:0] kbd_data,
    output logic       parity_err,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(STROBE_GAP + 1);

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic data_fall;

    ps2_line_filter #(.FILTER(FILTER)) u_clk_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (ps2_clk),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER(FILTER)) u_data_filt (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (ps2_data),
        .level   (data_level),
        .fall    (data_fall)
    );

    logic unused_filt;
    assign unused_filt = &{1'b0, clk_level, data_fall};

    ps2_state_t    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] tmo;

    logic frame_ok;
    logic push;
    logic tmo_hit;

    assign frame_ok = data_level && odd_parity_ok(shift, par);
    assign push     = clk_fall && (state == STOP) && frame_ok;
    assign tmo_hit  = (tmo == TW'(TIMEOUT_CYC));

    // Frame deserialiser with idle timeout; data sampled on clock fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par        <= 1'b0;
            tmo        <= '0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (state == IDLE || clk_fall) begin
                tmo <= '0;
            end else begin
                tmo <= tmo + 1'b1;
            end
            if (clk_fall) begin
                unique case (state)
                    IDLE: begin
                        if (!data_level) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_level, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= data_level;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            parity_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tmo_hit) begin
                state <= IDLE;
            end
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [GW-1:0] gap;

    logic empty;
    logic full;
    logic pop;
    logic do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && (gap == '0);
    assign do_push = push && (!full || pop);

    // Byte storage; validity lives in the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= shift;
        end
    end

    // FIFO pointers, overflow flag and paced strobe output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            gap        <= '0;
            overflow   <= 1'b0;
            kbd_strobe <= 1'b0;
            kbd_data   <= 8'h00;
        end else begin
            kbd_strobe <= pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                kbd_data <= mem[rd_ptr[AW-1:0]];
                gap      <= GW'(STROBE_GAP - 1);
            end else if (gap != '0) begin
                gap <= gap - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Bench for ps2_kbd_rx: frame vectors, glitches, timeout,
// FIFO overflow and asynchronous reset, with byte scoreboards.
module tb_ps2_kbd_rx;

    localparam int HALF_A = 40;
    localparam int HALF_B = 20;
    localparam int TMO_A  = 2000;
    localparam int GAP_A  = 16;
    localparam int GAP_B  = 4096;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic pclk    = 1'b1;
    logic pdat    = 1'b1;
    logic sel_b   = 1'b0;

    logic a_clk, a_dat, b_clk, b_dat;
    assign a_clk = sel_b ? 1'b1 : pclk;
    assign a_dat = sel_b ? 1'b1 : pdat;
    assign b_clk = sel_b ? pclk : 1'b1;
    assign b_dat = sel_b ? pdat : 1'b1;

    logic       a_strobe, a_perr, a_ovf;
    logic [7:0] a_data;
    logic       b_strobe, b_perr, b_ovf;
    logic [7:0] b_data;

    ps2_kbd_rx #(
        .FILTER      (8),
        .TIMEOUT_CYC (TMO_A),
        .FIFO_DEPTH  (4),
        .STROBE_GAP  (GAP_A)
    ) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (a_clk),
        .ps2_data   (a_dat),
        .kbd_strobe (a_strobe),
        .kbd_data   (a_data),
        .parity_err (a_perr),
        .overflow   (a_ovf)
    );

    ps2_kbd_rx #(
        .FILTER      (8),
        .TIMEOUT_CYC (32000),
        .FIFO_DEPTH  (4),
        .STROBE_GAP  (GAP_B)
    ) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (b_clk),
        .ps2_data   (b_dat),
        .kbd_strobe (b_strobe),
        .kbd_data   (b_data),
        .parity_err (b_perr),
        .overflow   (b_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    int strobes_a = 0;
    int strobes_b = 0;
    int err_a     = 0;
    int err_b     = 0;
    int last_a    = -1;
    int last_b    = -1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops expected bytes and checks strobe spacing.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_a = -1;
            last_b = -1;
        end else begin
            if (a_strobe) begin
                strobes_a++;
                if (q_a.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_spurious: got byte %h, none expected",
                             a_data);
                end else begin
                    check("a_byte", int'(a_data), int'(q_a.pop_front()));
                end
                if (last_a >= 0) begin
                    check("a_spacing_ok", int'((cyc - last_a) >= GAP_A), 1);
                end
                last_a = cyc;
            end
            if (b_strobe) begin
                strobes_b++;
                if (q_b.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_spurious: got byte %h, none expected",
                             b_data);
                end else begin
                    check("b_byte", int'(b_data), int'(q_b.pop_front()));
                end
                if (last_b >= 0) begin
                    check("b_spacing_ok", int'((cyc - last_b) >= GAP_B), 1);
                end
                last_b = cyc;
            end
            if (a_perr) err_a++;
            if (b_perr) err_b++;
        end
    end

    // Drive one frame (or its first nbits) on the selected pins.
    task automatic send_frame(
        input logic [7:0] b,
        input bit         flip_par,
        input bit         bad_stop,
        input int         nbits,
        input int         half,
        input int         glitch_bit
    );
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            repeat (half / 4) @(posedge clk);
            if (i == glitch_bit) begin
                pclk = 1'b0;
                repeat (2) @(posedge clk);
                pclk = 1'b1;
            end
            repeat (half / 4) @(posedge clk);
            pdat = f[i];
            repeat (half / 2) @(posedge clk);
            pclk = 1'b0;
            repeat (half / 2) @(posedge clk);
            if (i == glitch_bit) begin
                pclk = 1'b1;
                repeat (2) @(posedge clk);
                pclk = 1'b0;
            end
            repeat (half / 2) @(posedge clk);
            pclk = 1'b1;
        end
        repeat (half) @(posedge clk);
        pdat = 1'b1;
    endtask

    task automatic drain_a(input int budget);
        int k = 0;
        while (q_a.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("a_drain_left", q_a.size(), 0);
        q_a.delete();
    endtask

    task automatic drain_b(input int budget);
        int k = 0;
        while (q_b.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("b_drain_left", q_b.size(), 0);
        q_b.delete();
    endtask

    typedef struct {
        logic [7:0] b;
        bit         flip;
        bit         bad_stop;
        int         glitch;
        bit         exp_ok;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int s0;
        int e0;

        vecs[0] = '{8'h1C, 1'b1, 1'b0, -1, 1'b0, 8'h00};
        vecs[1] = '{8'h1C, 1'b0, 1'b0, -1, 1'b1, 8'h1C};
        vecs[2] = '{8'hF0, 1'b0, 1'b0, -1, 1'b1, 8'hF0};
        vecs[3] = '{8'h1C, 1'b0, 1'b0, -1, 1'b1, 8'h1C};
        vecs[4] = '{8'hE0, 1'b0, 1'b0, -1, 1'b1, 8'hE0};
        vecs[5] = '{8'h75, 1'b0, 1'b0, -1, 1'b1, 8'h75};
        vecs[6] = '{8'h00, 1'b0, 1'b1, -1, 1'b0, 8'h75};
        vecs[7] = '{8'hFF, 1'b0, 1'b0, -1, 1'b1, 8'hFF};
        vecs[8] = '{8'h3A, 1'b0, 1'b0, 4,  1'b1, 8'h3A};
        vecs[9] = '{8'h00, 1'b0, 1'b0, 0,  1'b1, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("rst_a_strobe", int'(a_strobe), 0);
        check("rst_a_data", int'(a_data), 0);
        check("rst_a_perr", int'(a_perr), 0);
        check("rst_a_ovf", int'(a_ovf), 0);
        check("rst_b_strobe", int'(b_strobe), 0);
        check("rst_b_ovf", int'(b_ovf), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);

        for (int v = 0; v < 10; v++) begin
            s0 = strobes_a;
            e0 = err_a;
            if (vecs[v].exp_ok) q_a.push_back(vecs[v].b);
            send_frame(vecs[v].b, vecs[v].flip, vecs[v].bad_stop,
                       11, HALF_A, vecs[v].glitch);
            drain_a(200);
            check($sformatf("vec%0d_strobes", v), strobes_a - s0,
                  int'(vecs[v].exp_ok));
            check($sformatf("vec%0d_errs", v), err_a - e0,
                  int'(!vecs[v].exp_ok));
            check($sformatf("vec%0d_data", v), int'(a_data),
                  int'(vecs[v].exp_data));
        end

        s0 = strobes_a;
        e0 = err_a;
        for (int g = 0; g < 3; g++) begin
            pclk = 1'b0;
            repeat (2) @(posedge clk);
            pclk = 1'b1;
            repeat (12) @(posedge clk);
        end
        repeat (50) @(posedge clk);
        check("idle_glitch_strobes", strobes_a - s0, 0);
        check("idle_glitch_errs", err_a - e0, 0);
        q_a.push_back(8'h29);
        send_frame(8'h29, 1'b0, 1'b0, 11, HALF_A, -1);
        drain_a(200);
        check("post_glitch_data", int'(a_data), 8'h29);

        s0 = strobes_a;
        e0 = err_a;
        send_frame(8'hAA, 1'b0, 1'b0, 5, HALF_A, -1);
        repeat (TMO_A + 200) @(posedge clk);
        check("tmo_partial_strobes", strobes_a - s0, 0);
        q_a.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b0, 11, HALF_A, -1);
        drain_a(200);
        check("tmo_strobes", strobes_a - s0, 1);
        check("tmo_errs", err_a - e0, 0);
        check("tmo_data", int'(a_data), 8'h5A);
        check("a_ovf_clear", int'(a_ovf), 0);

        sel_b = 1'b1;
        repeat (20) @(posedge clk);
        q_b.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 11, HALF_B, -1);
        drain_b(200);
        check("b_primer_strobes", strobes_b, 1);
        check("b_ovf_before", int'(b_ovf), 0);
        for (int i = 0; i < 4; i++) q_b.push_back(8'(8'h21 + i));
        for (int i = 0; i < 6; i++) begin
            send_frame(8'(8'h21 + i), 1'b0, 1'b0, 11, HALF_B, -1);
        end
        check("b_ovf_set", int'(b_ovf), 1);
        check("b_errs", err_b, 0);
        drain_b(20000);
        repeat (GAP_B + 100) @(posedge clk);
        check("b_total_strobes", strobes_b, 5);
        check("b_last_data", int'(b_data), 8'h24);
        check("b_ovf_sticky", int'(b_ovf), 1);

        sel_b = 1'b0;
        repeat (20) @(posedge clk);
        send_frame(8'hC3, 1'b0, 1'b0, 6, HALF_A, -1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_a_data", int'(a_data), 0);
        check("arst_a_strobe", int'(a_strobe), 0);
        check("arst_a_perr", int'(a_perr), 0);
        check("arst_b_ovf", int'(b_ovf), 0);
        check("arst_b_data", int'(b_data), 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        s0 = strobes_a;
        e0 = err_a;
        q_a.push_back(8'h33);
        send_frame(8'h33, 1'b0, 1'b0, 11, HALF_A, -1);
        drain_a(200);
        check("after_rst_strobes", strobes_a - s0, 1);
        check("after_rst_errs", err_a - e0, 0);
        check("after_rst_data", int'(a_data), 8'h33);

        repeat (10) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
